muldiv_mips: RTL and testbench
==============================

MULDIV_MIPS -- requirements
Module: muldiv_mips

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1, request to begin an operation.
REQ-004 SHALL have port op, input, 2, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports rs_data and rt_data, input, 32 each, operands taken from register-file readout1/readout2.
REQ-006 SHALL have ports mthi and mtlo, input, 1 each, write rs_data into hi/lo respectively.
REQ-007 SHALL have port busy, output, 1, high while an operation iterates.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking that hi/lo hold a new result.
REQ-009 SHALL have ports hi and lo, output, 32 each, architectural HI/LO registers.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE).
REQ-011 SHALL accept start only in IDLE or DONE; start SHALL be ignored in RUN.
REQ-012 SHALL latch op, rs_data, rt_data on the accepting edge E0 and SHALL ignore later operand changes.
REQ-013 SHALL perform one iteration per edge E1..E32: shift-add multiply or restoring divide on magnitudes, 6-bit iteration counter.
REQ-014 SHALL, at E32, commit the result to hi/lo and enter DONE; done high for exactly the cycle after E32, then IDLE unless start is accepted.
REQ-015 SHALL produce for MULT/MULTU a 64-bit product {hi,lo}, signed two's-complement for MULT, unsigned for MULTU.
REQ-016 SHALL produce for DIV/DIVU lo=quotient, hi=remainder; signed quotient truncates toward zero; signed remainder takes the dividend's sign.
REQ-017 SHALL, on divide by zero, still take 32 iterations and commit hi=rs_data, lo=32'hFFFFFFFF; no error signal.
REQ-018 SHALL, for DIV 32'h80000000 / 32'hFFFFFFFF, commit lo=32'h80000000, hi=0.
REQ-019 SHALL write hi<=rs_data on mthi and lo<=rs_data on mtlo when state is not RUN and no start is accepted that edge.
REQ-020 SHALL ignore mthi/mtlo while in RUN and on an edge where start is accepted (start wins).
REQ-021 SHALL leave hi/lo unchanged between commits except via mthi/mtlo.

Reset
REQ-022 SHALL, on reset at a rising edge, force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0.
REQ-023 SHALL, on reset during RUN, abort with no commit; reset SHALL override start, mthi, mtlo.

Configuration
REQ-024 SHALL support macro MULDIV_DIV_EN: defined -> DIV/DIVU per REQ-016..018.
REQ-025 SHALL, without MULDIV_DIV_EN, accept DIV/DIVU starts and go directly to DONE on the next edge with hi/lo unchanged; divider logic absent; multiply unaffected.

Verification
REQ-026 SHALL cover MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> done after E32, hi=32'hFFFFFFFE, lo=32'h00000001, busy high E0..E32.
REQ-027 SHALL cover MULT -3 x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-028 SHALL cover DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 100 / 0 -> hi=100, lo=32'hFFFFFFFF.
REQ-029 SHALL cover reset asserted at E10 of a MULTU 5x5 after mthi 32'hAB -> hi=0, lo=0, no done pulse.
REQ-030 SHALL cover mthi 32'h1234 during RUN -> ignored; mtlo 32'h55 in DONE cycle -> lo=32'h55 next edge.
REQ-031 SHALL cover start in DONE cycle (back-to-back MULTU 2x3 then 4x5) -> second done 33 edges after first, lo=6 then 20.

Source files
------------

// File: rtl/muldiv_mips.sv
// Iterative MIPS HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU complete at once with HI/LO untouched.
module muldiv_mips (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  // Magnitude of an operand; unsigned ops (op[0]=1) pass through untouched.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    if (is_signed && x[31]) begin
      mag32 = 32'd0 - x;
    end else begin
      mag32 = x;
    end
  endfunction

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] p_q, p_d;
  logic [31:0] a_q, a_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] iter_next;
  logic [63:0] prod_res;
  logic [31:0] commit_hi;
  logic [31:0] commit_lo;
  logic        accept;

`ifdef MULDIV_DIV_EN
  logic        is_div_q, is_div_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rs_q, rs_d;
  logic [32:0] rem_shift;
  logic [33:0] diff;
  logic [63:0] div_next;
`endif

  // One iteration step. Multiply: p = {acc, multiplier}; divide: p = {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, a_q} : 33'd0);
    mul_next = {mul_sum, p_q[31:1]};
`ifdef MULDIV_DIV_EN
    rem_shift = {p_q[63:32], p_q[31]};
    diff      = {1'b0, rem_shift} - {2'b00, b_q};
    if (diff[33]) begin
      div_next = {rem_shift[31:0], p_q[30:0], 1'b0};
    end else begin
      div_next = {diff[31:0], p_q[30:0], 1'b1};
    end
    if (is_div_q) begin
      iter_next = div_next;
    end else begin
      iter_next = mul_next;
    end
`else
    iter_next = mul_next;
`endif
  end

  // Sign-correct the final iteration into the values committed to HI/LO.
  always_comb begin
    if (sa_q ^ sb_q) begin
      prod_res = 64'd0 - iter_next;
    end else begin
      prod_res = iter_next;
    end
    commit_hi = prod_res[63:32];
    commit_lo = prod_res[31:0];
`ifdef MULDIV_DIV_EN
    if (is_div_q) begin
      if (b_q == 32'd0) begin
        commit_hi = rs_q;
        commit_lo = 32'hFFFF_FFFF;
      end else begin
        commit_lo = (sa_q ^ sb_q) ? (32'd0 - iter_next[31:0]) : iter_next[31:0];
        commit_hi = sa_q ? (32'd0 - iter_next[63:32]) : iter_next[63:32];
      end
    end else begin
      commit_hi = prod_res[63:32];
      commit_lo = prod_res[31:0];
    end
`endif
  end

  assign accept = start && (state_q != S_RUN);

  // Next-state logic: FSM, operand capture, iteration, commit and mthi/mtlo writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    a_d     = a_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    b_d      = b_q;
    rs_d     = rs_q;
`endif
    case (state_q)
      S_RUN: begin
        p_d   = iter_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_DONE;
          cnt_d   = 6'd0;
          hi_d    = commit_hi;
          lo_d    = commit_lo;
        end else begin
          state_d = S_RUN;
        end
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          cnt_d = 6'd0;
          a_d   = mag32(rs_data, ~op[0]);
          sa_d  = ~op[0] & rs_data[31];
          sb_d  = ~op[0] & rt_data[31];
`ifdef MULDIV_DIV_EN
          is_div_d = op[1];
          b_d      = mag32(rt_data, ~op[0]);
          rs_d     = rs_data;
          p_d      = op[1] ? {32'd0, mag32(rs_data, ~op[0])} : {32'd0, mag32(rt_data, ~op[0])};
          state_d  = S_RUN;
`else
          p_d      = {32'd0, mag32(rt_data, ~op[0])};
          state_d  = op[1] ? S_DONE : S_RUN;
`endif
        end else begin
          if (mthi) begin
            hi_d = rs_data;
          end else begin
            hi_d = hi_q;
          end
          if (mtlo) begin
            lo_d = rs_data;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation without a commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      p_q     <= 64'd0;
      a_q     <= 32'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      b_q      <= 32'd0;
      rs_q     <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      a_q     <= a_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
      is_div_q <= is_div_d;
      b_q      <= b_d;
      rs_q     <= rs_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_mips.sv
// Directed bench for muldiv_mips; divide vectors apply when MULDIV_DIV_EN is defined.
module tb_muldiv_mips;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  muldiv_mips dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for the single accepting edge, then scramble operands.
  task automatic do_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rs_data = 32'hDEAD_BEEF; rt_data = 32'h0BAD_F00D;
  endtask

  // Edges after the accepting edge until done is seen, bounded at 40.
  task automatic wait_done(output int edges, output int busy_bad);
    edges = 0; busy_bad = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mthi = 1'b1; mtlo = 1'b1; rs_data = 32'hFFFF_0000; start = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got %h exp 0", lo); end
    reset = 1'b0; mthi = 1'b0; mtlo = 1'b0; start = 1'b0; rs_data = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_multu_max;
    int e, bb;
    do_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(e, bb);
    checks++; if (e !== 32) begin failures++; $display("FAIL multu_max_latency got %0d exp 32", e); end
    checks++; if (bb !== 0) begin failures++; $display("FAIL multu_max_busy got %0d low cycles exp 0", bb); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_max_busy_done got %b exp 0", busy); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_max_hi got %h exp fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_max_lo got %h exp 00000001", lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_max_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_mult_patterns;
    logic [1:0]  ops [4];
    logic [31:0] av  [4];
    logic [31:0] bv  [4];
    logic [63:0] ev  [4];
    int e, bb;
    ops[0] = OP_MULT;  av[0] = 32'hFFFF_FFFD; bv[0] = 32'd7;         ev[0] = 64'hFFFF_FFFF_FFFF_FFEB;
    ops[1] = OP_MULT;  av[1] = 32'h8000_0000; bv[1] = 32'h8000_0000; ev[1] = 64'h4000_0000_0000_0000;
    ops[2] = OP_MULTU; av[2] = 32'h1234_5678; bv[2] = 32'h0000_0010; ev[2] = 64'h0000_0001_2345_6780;
    ops[3] = OP_MULT;  av[3] = 32'hFFFF_FFFF; bv[3] = 32'hFFFF_FFFF; ev[3] = 64'h0000_0000_0000_0001;
    for (int i = 0; i < 4; i++) begin
      do_start(ops[i], av[i], bv[i]);
      wait_done(e, bb);
      checks++; if (e !== 32) begin failures++; $display("FAIL mult%0d_latency got %0d exp 32", i, e); end
      checks++; if ({hi, lo} !== ev[i]) begin failures++; $display("FAIL mult%0d_result got %h exp %h", i, {hi, lo}, ev[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_div;
    int e, bb;
`ifdef MULDIV_DIV_EN
    logic [1:0]  ops [5];
    logic [31:0] av  [5];
    logic [31:0] bv  [5];
    logic [63:0] ev  [5];
    ops[0] = OP_DIV;  av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2;         ev[0] = 64'hFFFF_FFFF_FFFF_FFFD;
    ops[1] = OP_DIVU; av[1] = 32'd100;       bv[1] = 32'd0;         ev[1] = 64'h0000_0064_FFFF_FFFF;
    ops[2] = OP_DIV;  av[2] = 32'h8000_0000; bv[2] = 32'hFFFF_FFFF; ev[2] = 64'h0000_0000_8000_0000;
    ops[3] = OP_DIVU; av[3] = 32'd100;       bv[3] = 32'd7;         ev[3] = 64'h0000_0002_0000_000E;
    ops[4] = OP_DIV;  av[4] = 32'd7;         bv[4] = 32'hFFFF_FFFE; ev[4] = 64'h0000_0001_FFFF_FFFD;
    for (int i = 0; i < 5; i++) begin
      do_start(ops[i], av[i], bv[i]);
      wait_done(e, bb);
      checks++; if (e !== 32) begin failures++; $display("FAIL div%0d_latency got %0d exp 32", i, e); end
      checks++; if ({hi, lo} !== ev[i]) begin failures++; $display("FAIL div%0d_result got %h exp %h", i, {hi, lo}, ev[i]); end
      @(negedge clk);
    end
`else
    rs_data = 32'h0000_1111; mthi = 1'b1; @(negedge clk); mthi = 1'b0;
    rs_data = 32'h0000_2222; mtlo = 1'b1; @(negedge clk); mtlo = 1'b0;
    do_start(OP_DIV, 32'd100, 32'd7);
    wait_done(e, bb);
    checks++; if (e !== 0) begin failures++; $display("FAIL div_off_latency got %0d exp 0", e); end
    checks++; if ({hi, lo} !== 64'h0000_1111_0000_2222) begin failures++; $display("FAIL div_off_hilo got %h exp 0000111100002222", {hi, lo}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL div_off_done_pulse got %b exp 0", done); end
`endif
  endtask

  task automatic test_reset_abort;
    int seen;
    rs_data = 32'h0000_00AB; mthi = 1'b1; @(negedge clk); mthi = 1'b0;
    checks++; if (hi !== 32'h0000_00AB) begin failures++; $display("FAIL mthi_ab got %h exp 000000ab", hi); end
    do_start(OP_MULTU, 32'd5, 32'd5);
    for (int i = 0; i < 9; i++) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL abort_hilo got %h exp 0", {hi, lo}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b exp 0", busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done got %0d pulses exp 0", seen); end
  endtask

  task automatic test_mthi_mtlo_timing;
    int e, bb;
    do_start(OP_MULTU, 32'd3, 32'd4);
    rs_data = 32'h0000_1234; mthi = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    mthi = 1'b0;
    wait_done(e, bb);
    checks++; if ({hi, lo} !== 64'h0000_0000_0000_000C) begin failures++; $display("FAIL mthi_run_ignored got %h exp c", {hi, lo}); end
    rs_data = 32'h0000_0055; mtlo = 1'b1; @(negedge clk); mtlo = 1'b0;
    checks++; if (lo !== 32'h0000_0055) begin failures++; $display("FAIL mtlo_done got %h exp 00000055", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL mtlo_done_hi got %h exp 0", hi); end
  endtask

  task automatic test_back_to_back;
    int e1, e2, bb;
    do_start(OP_MULTU, 32'd2, 32'd3);
    wait_done(e1, bb);
    checks++; if (lo !== 32'd6) begin failures++; $display("FAIL b2b_first_lo got %h exp 6", lo); end
    do_start(OP_MULTU, 32'd4, 32'd5);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got %b exp 1", busy); end
    for (int i = 0; i < 3; i++) @(negedge clk);
    do_start(OP_MULTU, 32'd7, 32'd7);
    checks++; if (lo !== 32'd6) begin failures++; $display("FAIL b2b_lo_hold got %h exp 6", lo); end
    wait_done(e2, bb);
    checks++; if (1 + 4 + e2 !== 33) begin failures++; $display("FAIL b2b_gap got %0d exp 33", 1 + 4 + e2); end
    checks++; if (lo !== 32'd20) begin failures++; $display("FAIL b2b_second_lo got %h exp 14", lo); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = 32'd0; rt_data = 32'd0;
    mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    test_reset();
    test_multu_max();
    test_mult_patterns();
    test_div();
    test_reset_abort();
    test_mthi_mtlo_timing();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
